// File: rtl/sram_bank_loader_pkg.sv
// Shared network parameters for the SRAM bank loader slice.
// Holds the default bus widths, the layer shape constants and the
// loader FSM state type. No ports.
package sram_bank_loader_pkg;

  localparam int N_BANKS = 64;   // interleaved SRAM banks
  localparam int DATA_W  = 16;   // fixed-point word width
  localparam int ADDR_W  = 12;   // per-bank address (13*200 = 2600 words)
  localparam int LEN_W   = 10;   // vector length (max 784)
  localparam int ROW_W   = 8;    // row count (max 200)

  // Layer shapes of the network being staged into the banks.
  localparam int IMG_LEN = 784;
  localparam int L1_ROWS = 200;
  localparam int L2_LEN  = 200;
  localparam int L2_ROWS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/sram_bank_loader_if.sv
// Control, stream and bank-write bundle of the SRAM bank loader.
//   master : issues start/vec_len/num_rows, drives the word stream and
//            observes s_ready, the bank write port and busy/done.
//   slave  : the loader itself.
// Signals:
//   start, vec_len, num_rows  - load request (L words per row, R rows)
//   s_valid, s_data, s_ready  - row-major input stream handshake
//   bank_we, bank_addr,
//   bank_wdata                - one-hot write enable, shared addr/data
//   busy, done                - load in progress / completion pulse
interface sram_bank_loader_if #(
  parameter int N_BANKS = sram_bank_loader_pkg::N_BANKS,
  parameter int DATA_W  = sram_bank_loader_pkg::DATA_W,
  parameter int ADDR_W  = sram_bank_loader_pkg::ADDR_W,
  parameter int LEN_W   = sram_bank_loader_pkg::LEN_W,
  parameter int ROW_W   = sram_bank_loader_pkg::ROW_W
) ();

  logic               start;
  logic [LEN_W-1:0]   vec_len;
  logic [ROW_W-1:0]   num_rows;
  logic               s_valid;
  logic [DATA_W-1:0]  s_data;
  logic               s_ready;
  logic [N_BANKS-1:0] bank_we;
  logic [ADDR_W-1:0]  bank_addr;
  logic [DATA_W-1:0]  bank_wdata;
  logic               busy;
  logic               done;

  modport master (
    output start, vec_len, num_rows, s_valid, s_data,
    input  s_ready, bank_we, bank_addr, bank_wdata, busy, done
  );

  modport slave (
    input  start, vec_len, num_rows, s_valid, s_data,
    output s_ready, bank_we, bank_addr, bank_wdata, busy, done
  );

endinterface

// File: rtl/sram_bank_loader_bank_addr_gen.sv
// Bank select and address generation for the loader.
// Ports:
//   b          - current bank index (word n mod N_BANKS)
//   r          - L mod N_BANKS; banks below r hold one extra word per row
//   j          - offset within the row slice of bank b (n div N_BANKS)
//   base_long  - row base for banks holding q+1 words per row
//   base_short - row base for banks holding q words per row
//   sel        - one-hot bank select decoded from b
//   addr       - bank address: chosen base + j
module bank_addr_gen #(
  parameter int N_BANKS = 64,
  parameter int ADDR_W  = 12,
  parameter int BANK_W  = $clog2(N_BANKS)
) (
  input  logic [BANK_W-1:0]  b,
  input  logic [BANK_W-1:0]  r,
  input  logic [ADDR_W-1:0]  j,
  input  logic [ADDR_W-1:0]  base_long,
  input  logic [ADDR_W-1:0]  base_short,
  output logic [N_BANKS-1:0] sel,
  output logic [ADDR_W-1:0]  addr
);

  logic long_bank;

  // Banks 0..r-1 carry q+1 words per row, the rest carry q.
  assign long_bank = (b < r);
  assign addr      = (long_bank ? base_long : base_short) + j;

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_sel
    assign sel[gi] = (b == BANK_W'(gi));
  end

endmodule

// File: rtl/sram_bank_loader.sv
// Scatters a row-major stream of R rows x L words into N_BANKS
// interleaved SRAM banks. Word n of row k lands in bank n mod N_BANKS
// at address k*W(b) + n div N_BANKS, where W(b) is the number of words
// that bank holds per row. The k*W(b) product is replaced by two
// running bases advanced once per row.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active high
//   bus   - sram_bank_loader_if.slave: request, stream, bank port,
//           busy/done
module sram_bank_loader
  import sram_bank_loader_pkg::*;
#(
  parameter int N_BANKS = sram_bank_loader_pkg::N_BANKS,
  parameter int DATA_W  = sram_bank_loader_pkg::DATA_W,
  parameter int ADDR_W  = sram_bank_loader_pkg::ADDR_W,
  parameter int LEN_W   = sram_bank_loader_pkg::LEN_W,
  parameter int ROW_W   = sram_bank_loader_pkg::ROW_W
) (
  input  logic clk,
  input  logic reset,
  sram_bank_loader_if.slave bus
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int STAGES = 1;   // accept -> bank port latency

  state_e state, state_nxt;

  // Job parameters latched at start.
  logic [LEN_W-1:0]   len_q;
  logic [ROW_W-1:0]   rows_q;
  logic [ADDR_W-1:0]  q_q;
  logic [BANK_W-1:0]  r_q;

  // Walk position within the job.
  logic [BANK_W-1:0]  b_q;
  logic [ADDR_W-1:0]  j_q;
  logic [LEN_W-1:0]   n_q;
  logic [ROW_W-1:0]   row_q;
  logic [ADDR_W-1:0]  base_long_q;
  logic [ADDR_W-1:0]  base_short_q;

  // Write stage.
  logic [N_BANKS-1:0] sel, sel_q;
  logic [ADDR_W-1:0]  addr, addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STAGES:0]    vld_pipe;
  logic [STAGES:1]    vld_q;

  logic accept, last_word, last_row, empty_job;
  logic s_ready_c, busy_c, done_c;

  assign accept    = bus.s_valid && (state == LOAD);
  assign last_word = (n_q == len_q - LEN_W'(1));
  assign last_row  = (row_q == rows_q - ROW_W'(1));
  assign empty_job = (bus.vec_len == '0) || (bus.num_rows == '0);

  assign vld_pipe  = {vld_q, accept};

  bank_addr_gen #(
    .N_BANKS (N_BANKS),
    .ADDR_W  (ADDR_W),
    .BANK_W  (BANK_W)
  ) u_addr_gen (
    .b          (b_q),
    .r          (r_q),
    .j          (j_q),
    .base_long  (base_long_q),
    .base_short (base_short_q),
    .sel        (sel),
    .addr       (addr)
  );

  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      IDLE: begin
        // An empty job skips LOAD so done still pulses exactly once.
        if (bus.start) state_nxt = empty_job ? FINISH : LOAD;
      end
      LOAD: begin
        s_ready_c = 1'b1;
        busy_c    = 1'b1;
        if (accept && last_word && last_row) state_nxt = FINISH;
      end
      FINISH: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      rows_q       <= '0;
      q_q          <= '0;
      r_q          <= '0;
      b_q          <= '0;
      j_q          <= '0;
      n_q          <= '0;
      row_q        <= '0;
      base_long_q  <= '0;
      base_short_q <= '0;
      sel_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      vld_q        <= '0;
    end else begin
      state <= state_nxt;
      vld_q <= vld_pipe[STAGES-1:0];

      if (state == IDLE && bus.start) begin
        len_q        <= bus.vec_len;
        rows_q       <= bus.num_rows;
        q_q          <= ADDR_W'(int'(bus.vec_len) / N_BANKS);
        r_q          <= BANK_W'(int'(bus.vec_len) % N_BANKS);
        b_q          <= '0;
        j_q          <= '0;
        n_q          <= '0;
        row_q        <= '0;
        base_long_q  <= '0;
        base_short_q <= '0;
      end else if (accept) begin
        if (last_word) begin
          // Row done: every bank moves on by the number of words it
          // holds per row.
          n_q          <= '0;
          b_q          <= '0;
          j_q          <= '0;
          row_q        <= row_q + ROW_W'(1);
          base_long_q  <= base_long_q + q_q + ADDR_W'(1);
          base_short_q <= base_short_q + q_q;
        end else begin
          n_q <= n_q + LEN_W'(1);
          if (b_q == BANK_W'(N_BANKS - 1)) begin
            b_q <= '0;
            j_q <= j_q + ADDR_W'(1);
          end else begin
            b_q <= b_q + BANK_W'(1);
          end
        end
      end

      if (accept) begin
        sel_q   <= sel;
        addr_q  <= addr;
        wdata_q <= bus.s_data;
      end
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.bank_we    = vld_pipe[STAGES] ? sel_q : '0;
  assign bus.bank_addr  = addr_q;
  assign bus.bank_wdata = wdata_q;

endmodule

// File: tb/tb_sram_bank_loader.sv
module tb_sram_bank_loader;
  import sram_bank_loader_pkg::*;

  typedef struct {
    logic [N_BANKS-1:0] we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
    bit                 last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  sram_bank_loader_if bus ();

  sram_bank_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   exp_empty_done = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference placement: word n of row k, straight from the layout rule.
  function automatic exp_t model(input int len, input int k, input int n,
                                 input logic [DATA_W-1:0] d, input bit last);
    exp_t e;
    int b, j, w;
    b = n % N_BANKS;
    j = n / N_BANKS;
    w = (len / N_BANKS) + ((b < (len % N_BANKS)) ? 1 : 0);
    e.we    = '0;
    e.we[b] = 1'b1;
    e.addr  = ADDR_W'(k * w + j);
    e.data  = d;
    e.last  = last;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int rows);
    bus.start    = 1'b1;
    bus.vec_len  = LEN_W'(len);
    bus.num_rows = ROW_W'(rows);
    tick();
    bus.start    = 1'b0;
    bus.vec_len  = LEN_W'($urandom);
    bus.num_rows = ROW_W'($urandom);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdy = bus.s_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_idle"}, 64'(ok), 64'd1);
    tick();
  endtask

  // gap_mode: 0 continuous valid, 1 valid toggling 1/0, 2 random gaps.
  task automatic run_job(input int len, input int rows, input int gap_mode,
                         input int disturb_at, input string name);
    bit ok;
    int idx, gaps;
    logic [DATA_W-1:0] d;
    idx = 0;
    start_job(len, rows);
    for (int k = 0; k < rows; k++) begin
      for (int n = 0; n < len; n++) begin
        d = DATA_W'($urandom);
        send_word(d, ok);
        if (!ok) begin
          chk({name, "_accept"}, 64'd0, 64'd1);
          return;
        end
        exp_q.push_back(model(len, k, n, d, (k == rows - 1) && (n == len - 1)));
        gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        if (idx == disturb_at) begin
          bus.start    = 1'b1;
          bus.vec_len  = LEN_W'($urandom);
          bus.num_rows = ROW_W'($urandom);
          if (gaps == 0) gaps = 1;
        end
        repeat (gaps) begin
          bus.s_data = DATA_W'($urandom);
          tick();
          bus.start = 1'b0;
        end
        idx++;
      end
    end
    wait_idle(name);
  endtask

  // Scoreboard monitor: every bank write must match the next expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.bank_we != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(bus.bank_we), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_we", 64'(bus.bank_we), 64'(e.we));
          chk("wr_addr", 64'(bus.bank_addr), 64'(e.addr));
          chk("wr_data", 64'(bus.bank_wdata), 64'(e.data));
          chk("done_with_last", 64'(bus.done), 64'(e.last));
        end
      end else if (bus.done) begin
        if (exp_empty_done > 0) begin
          chk("empty_done", 64'(bus.done), 64'd1);
          exp_empty_done--;
        end else begin
          chk("unexpected_done", 64'(bus.done), 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [DATA_W-1:0] d;
    int len, rows;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.vec_len  = '0;
    bus.num_rows = '0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_we", 64'(bus.bank_we), 64'd0);
    chk("rst_addr", 64'(bus.bank_addr), 64'd0);
    chk("rst_wdata", 64'(bus.bank_wdata), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_s_ready", 64'(bus.s_ready), 64'd0);
    tick();

    // Image row and layer shapes.
    run_job(IMG_LEN, 1, 0, -1, "img");
    run_job(IMG_LEN, 3, 2, -1, "l1");
    run_job(13, L1_ROWS, 0, -1, "l1_all_rows");
    run_job(L2_LEN, L2_ROWS, 1, 57, "l2");

    // Empty jobs: done one cycle after start, no stream, no writes.
    exp_empty_done++;
    start_job(0, 5);
    @(negedge clk);
    chk("empty_l_done", 64'(bus.done), 64'd1);
    chk("empty_l_ready", 64'(bus.s_ready), 64'd0);
    chk("empty_l_we", 64'(bus.bank_we), 64'd0);
    tick();
    @(negedge clk);
    chk("empty_l_done_low", 64'(bus.done), 64'd0);
    chk("empty_l_busy_low", 64'(bus.busy), 64'd0);
    tick();
    exp_empty_done++;
    start_job(7, 0);
    @(negedge clk);
    chk("empty_r_done", 64'(bus.done), 64'd1);
    chk("empty_r_ready", 64'(bus.s_ready), 64'd0);
    tick();
    tick();

    // Reset after 100 words of an image load, then restart.
    start_job(IMG_LEN, 1);
    for (int n = 0; n < 100; n++) begin
      d = DATA_W'($urandom);
      send_word(d, ok);
      if (ok) exp_q.push_back(model(IMG_LEN, 0, n, d, 1'b0));
      else chk("rst_mid_accept", 64'd0, 64'd1);
    end
    reset       = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = DATA_W'($urandom);
    tick();
    @(negedge clk);
    chk("rst_mid_we", 64'(bus.bank_we), 64'd0);
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_mid_addr", 64'(bus.bank_addr), 64'd0);
    chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
    reset       = 1'b0;
    bus.s_valid = 1'b0;
    run_job(IMG_LEN, 1, 0, -1, "after_rst");

    // Bank-count boundaries and short rows.
    run_job(20, 5, 2, 33, "short_rows");
    run_job(N_BANKS, 3, 0, -1, "exact_banks");
    run_job(N_BANKS + 1, 2, 2, -1, "banks_plus1");
    run_job(1, 4, 1, -1, "len1");

    // Random shapes, gaps and stray start pulses.
    for (int t = 0; t < 6; t++) begin
      len  = int'($urandom_range(1, 200));
      rows = int'($urandom_range(1, 4));
      run_job(len, rows, 2, int'($urandom_range(0, len * rows - 1)), "rand");
    end

    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("empty_done_seen", 64'(exp_empty_done), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_bank_loader.md
SRAM_BANK_LOADER -- requirements
Module: sram_bank_loader

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  - N_BANKS, 64, number of interleaved SRAM banks.
  - DATA_W, 16, fixed-point word width.
  - ADDR_W, 12, per-bank address width (covers 13*200 = 2600 words).
  - LEN_W, 10, vector-length width (max 784).
  - ROW_W, 8, row-count width (max 200).
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  - clk, in, 1, single clock; all logic on rising edge.
  - reset, in, 1, synchronous, active-high.
  - start, in, 1, one-cycle request to begin a load.
  - vec_len, in, LEN_W, words per row (L).
  - num_rows, in, ROW_W, rows to load (R).
  - s_valid, in, 1, stream word valid.
  - s_data, in, DATA_W, stream word.
  - s_ready, out, 1, loader accepts word.
  - bank_we, out, N_BANKS, one-hot write enable.
  - bank_addr, out, ADDR_W, address shared by all banks.
  - bank_wdata, out, DATA_W, write data shared by all banks.
  - busy, out, 1, load in progress.
  - done, out, 1, one-cycle completion pulse.

Function
REQ-003 SHALL scatter a row-major stream of R rows x L words into banks; word n of row k goes to bank b = n mod N_BANKS at offset j = n div N_BANKS.
REQ-004 SHALL compute words per row for bank b as W(b) = q + (b < r), where q = L div N_BANKS and r = L mod N_BANKS.
REQ-005 SHALL write to address k*W(b) + j.
REQ-006 SHALL produce that address without a multiplier:
  - keep running bases base_long (step q+1 per row) and base_short (step q per row);
  - address = (b < r ? base_long : base_short) + j.
REQ-007 SHALL use states IDLE, LOAD and FINISH:
  - IDLE -> LOAD on start, latching L, R, q and r.
  - LOAD -> FINISH when the last word (row R-1, n = L-1) is accepted.
  - FINISH -> IDLE after one cycle.
REQ-008 SHALL ignore start while in LOAD or FINISH; vec_len and num_rows changes during a load SHALL have no effect.
REQ-009 SHALL drive s_ready = 1 only in LOAD; a word is accepted when s_valid && s_ready.
REQ-010 SHALL have write latency of one cycle:
  - a word accepted in cycle t appears on bank_we, bank_addr and bank_wdata in cycle t+1;
  - bank_we SHALL be all-zero in any cycle with no accepted word in t.
REQ-011 SHALL hold counters (b, j, row, bases) unchanged while s_valid = 0; gaps SHALL produce no writes.
REQ-012 SHALL advance counters on acceptance:
  - b wraps N_BANKS-1 -> 0 and increments j;
  - at n = L-1: b, j -> 0, row increments, bases advance.
REQ-013 SHALL assert done in the FINISH cycle, which is the same cycle the last write appears on the bank port.
REQ-014 SHALL assert busy in LOAD and FINISH.
REQ-015 SHALL go IDLE -> FINISH with no writes and no s_ready if start arrives with L = 0 or R = 0.
REQ-016 SHALL support L < N_BANKS (q = 0): only banks 0..L-1 are written, at address k.

Reset
REQ-017 SHALL on reset force:
  - state = IDLE;
  - s_ready, busy, done = 0 and bank_we = 0;
  - bank_addr and bank_wdata = 0;
  - all counters and bases = 0.
REQ-018 SHALL, on reset mid-LOAD, abort with no further writes and no done pulse, and SHALL accept a new start the cycle after reset deasserts.

Structure
REQ-019 SHALL take N_BANKS, DATA_W, ADDR_W, LEN_W and ROW_W from the shared network-parameter package, together with the layer constants:
  - IMG_LEN = 784
  - L1_ROWS = 200
  - L2_LEN = 200
  - L2_ROWS = 10
REQ-020 SHALL place the bank-select decode (one-hot from b) and the long/short address select in one sub-module, bank_addr_gen.

Verification
REQ-021 Image, L=784, R=1, continuous valid:
  - word 0 -> bank 0 addr 0;
  - word 783 -> bank 15 addr 12;
  - exactly 784 writes; done coincides with the last write.
REQ-022 Layer-1 weights, L=784, R=200:
  - row 1 word 0 -> bank 0 addr 13;
  - row 1 word 16 -> bank 16 addr 12;
  - row 199 word 783 -> bank 15 addr 2599.
REQ-023 Layer-2 weights, L=200, R=10, s_valid toggling 1/0:
  - row 2 word 8 -> bank 8 addr 6;
  - row 9 word 199 -> bank 7 addr 39;
  - no writes in gap cycles.
REQ-024 start with L=0, R=5:
  - done pulses 1 cycle after start;
  - s_ready and bank_we stay 0.
REQ-025 Reset asserted after 100 words of a 784-word load:
  - next cycle bank_we = 0, busy = 0;
  - a new start then loads word 0 to bank 0 addr 0.
REQ-026 start pulsed again mid-LOAD:
  - ignored; counters and addresses continue unchanged.
